// File: rtl/set_assoc_cache.sv
// Set-associative write-back cache with one-word lines; hits answer combinationally in IDLE.
// Misses stall through optional WRITEBACK and a REFILL, then re-evaluate as a hit one cycle later.
module set_assoc_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8,
   parameter int WAYS       = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    MemRead,
   input  logic                    MemWrite,
   input  logic [ADDR_WIDTH-1:0]   A,
   input  logic [DATA_WIDTH-1:0]   WD,
   input  logic [DATA_WIDTH/8-1:0] BE,
   output logic [DATA_WIDTH-1:0]   RD,
   output logic                    hit,
   output logic                    Stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int IDXW  = $clog2(SETS);
   localparam int TAGW  = ADDR_WIDTH - IDXW - OFFW;
   localparam int PTRW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t                 state;
   logic [WAYS-1:0]        validArr [SETS];
   logic [WAYS-1:0]        dirtyArr [SETS];
   logic [PTRW-1:0]        repPtr   [SETS];
   logic [TAGW-1:0]        tagArr   [SETS][WAYS];
   logic [DATA_WIDTH-1:0]  dataArr  [SETS][WAYS];

   logic [PTRW-1:0]        victimWay;
   logic                   usedInvalid;

   logic                   access;
   logic [IDXW-1:0]        idx;
   logic [TAGW-1:0]        tagA;
   logic                   anyHit;
   logic [PTRW-1:0]        hitWay;
   logic                   anyInvalid;
   logic [PTRW-1:0]        vicWay;
   logic                   vicDirty;
   logic [ADDR_WIDTH-1:0]  vicAddr;
   logic [ADDR_WIDTH-1:0]  fillAddr;
   logic                   idleHit;

   assign access = MemRead | MemWrite;
   assign idx    = A[OFFW +: IDXW];
   assign tagA   = A[ADDR_WIDTH-1 -: TAGW];

   always_comb begin
      anyHit = 1'b0;
      hitWay = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!anyHit && validArr[idx][w] && tagArr[idx][w] == tagA) begin
            anyHit = 1'b1;
            hitWay = PTRW'(w);
         end
      end
   end

   // Lowest-index empty way wins; the round-robin pointer only matters when the set is full.
   always_comb begin
      anyInvalid = 1'b0;
      vicWay     = repPtr[idx];
      for (int w = 0; w < WAYS; w++) begin
         if (!anyInvalid && !validArr[idx][w]) begin
            anyInvalid = 1'b1;
            vicWay     = PTRW'(w);
         end
      end
   end

   assign vicDirty = validArr[idx][vicWay] & dirtyArr[idx][vicWay];
   assign vicAddr  = ADDR_WIDTH'({tagArr[idx][vicWay], idx}) << OFFW;
   assign fillAddr = A & ~ADDR_WIDTH'((1 << OFFW) - 1);

   assign idleHit = (state == IDLE) && access && anyHit;
   assign hit     = !RST && idleHit;
   assign Stall   = !RST && ((state != IDLE) || (access && !anyHit));
   assign RD      = idleHit ? dataArr[idx][hitWay] : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         victimWay   <= '0;
         usedInvalid <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         for (int s = 0; s < SETS; s++) begin
            validArr[s] <= '0;
            dirtyArr[s] <= '0;
            repPtr[s]   <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (access && !anyHit) begin
                  victimWay   <= vicWay;
                  usedInvalid <= anyInvalid;
                  mem_req     <= 1'b1;
                  if (vicDirty) begin
                     state     <= WRITEBACK;
                     mem_we    <= 1'b1;
                     mem_addr  <= vicAddr;
                     mem_wdata <= dataArr[idx][vicWay];
                  end else begin
                     state     <= REFILL;
                     mem_we    <= 1'b0;
                     mem_addr  <= fillAddr;
                     mem_wdata <= '0;
                  end
               end else if (idleHit && MemWrite) begin
                  dirtyArr[idx][hitWay] <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  state     <= REFILL;
                  mem_we    <= 1'b0;
                  mem_addr  <= fillAddr;
                  mem_wdata <= '0;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  state                    <= IDLE;
                  mem_req                  <= 1'b0;
                  mem_addr                 <= '0;
                  validArr[idx][victimWay] <= 1'b1;
                  dirtyArr[idx][victimWay] <= 1'b0;
                  if (!usedInvalid)
                     repPtr[idx] <= (repPtr[idx] == PTRW'(WAYS - 1)) ? '0 : repPtr[idx] + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag and data storage carry no reset; validity alone decides whether they mean anything.
   always_ff @(posedge CLK) begin
      if (state == REFILL && mem_ready) begin
         dataArr[idx][victimWay] <= mem_rdata;
         tagArr[idx][victimWay]  <= tagA;
      end else if (idleHit && MemWrite) begin
         for (int b = 0; b < BYTES; b++) begin
            if (BE[b])
               dataArr[idx][hitWay][8*b +: 8] <= WD[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed and randomized checks of set_assoc_cache against a transparent-memory golden model
// plus a per-set occupancy model that predicts hits and write-backs.
module tb_set_assoc_cache;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] A = '0, WD = '0;
   logic [3:0]  BE = '0;
   logic [31:0] RD;
   logic        hit, Stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   set_assoc_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(8), .WAYS(2)) dut (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .A(A), .WD(WD), .BE(BE),
      .RD(RD), .hit(hit), .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   int nCmp = 0, nErr = 0;
   int wbCount = 0;
   logic [31:0] lastWbAddr = '0, lastWbData = '0;

   logic [31:0] mem  [logic [31:0]];
   logic [31:0] gold [logic [31:0]];

   bit          mValid [8][2];
   bit          mDirty [8][2];
   logic [26:0] mTag   [8][2];
   int          mPtr   [8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memGet(input logic [31:0] ad);
      return mem.exists(ad) ? mem[ad] : (ad ^ 32'h5A5A_0000);
   endfunction

   function automatic logic [31:0] goldGet(input logic [31:0] ad);
      return gold.exists(ad) ? gold[ad] : memGet(ad);
   endfunction

   task automatic clearModel();
      for (int s = 0; s < 8; s++) begin
         mPtr[s] = 0;
         for (int w = 0; w < 2; w++) begin
            mValid[s][w] = 0;
            mDirty[s][w] = 0;
         end
      end
   endtask

   task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int lat,
                         output logic [31:0] rdv, output int cyc);
      logic [31:0] key;
      logic [31:0] g;
      logic [26:0] tg;
      int s, way, reqCnt, wb0;
      bit pHit, expWb;
      key = a & ~32'd3;
      s = int'(a[4:2]);
      tg = a[31:5];
      pHit = 0; way = 0; expWb = 0; reqCnt = 0; wb0 = wbCount;
      for (int i = 0; i < 2; i++)
         if (!pHit && mValid[s][i] && mTag[s][i] == tg) begin pHit = 1; way = i; end
      if (!pHit) begin
         if (!mValid[s][0]) way = 0;
         else if (!mValid[s][1]) way = 1;
         else begin way = mPtr[s]; mPtr[s] = (mPtr[s] + 1) % 2; end
         expWb = mValid[s][way] && mDirty[s][way];
         mValid[s][way] = 1; mDirty[s][way] = 0; mTag[s][way] = tg;
      end

      MemRead = r; MemWrite = w; A = a; WD = wd; BE = be;
      #1;
      chk("hit_first", hit, pHit);
      if (!pHit) chk("miss_stall", Stall, 1);
      cyc = 0;
      while (!hit && cyc < 100) begin
         if (mem_req) begin
            reqCnt++;
            if (reqCnt >= lat) begin
               if (mem_we) begin
                  chk("wb_data", mem_wdata, goldGet(mem_addr));
                  mem[mem_addr] = mem_wdata;
                  wbCount++;
                  lastWbAddr = mem_addr;
                  lastWbData = mem_wdata;
               end else begin
                  chk("refill_addr", mem_addr, key);
                  mem_rdata = memGet(mem_addr);
               end
               mem_ready = 1'b1;
               reqCnt = 0;
            end
         end
         @(posedge CLK); #1;
         mem_ready = 1'b0;
         cyc++;
      end
      if (!hit) chk("timeout_hit", hit, 1);
      rdv = RD;
      if (r && !w) chk("rdata", RD, goldGet(key));
      chk("wb_count", 64'(wbCount - wb0), 64'(expWb));
      if (w) begin
         g = goldGet(key);
         for (int b = 0; b < 4; b++)
            if (be[b]) g[8*b +: 8] = wd[8*b +: 8];
         gold[key] = g;
         mDirty[s][way] = 1;
      end
      @(posedge CLK); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   initial begin
      logic [31:0] rdv;
      int cyc;
      mem[32'h100] = 32'hDEAD_BEEF;
      clearModel();

      // Reset state
      #2;
      chk("rst_hit", hit, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_memreq", mem_req, 0);
      chk("rst_memwe", mem_we, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Cold read: one IDLE miss cycle plus three memory cycles
      access(1, 0, 32'h100, 0, 0, 3, rdv, cyc);
      chk("cold_rd", rdv, 32'hDEAD_BEEF);
      chk("cold_latency", cyc, 4);

      // Byte write hit, then read back merged word
      access(0, 1, 32'h100, 32'h0000_00AA, 4'b0001, 1, rdv, cyc);
      chk("wr_hit_nomem", cyc, 0);
      access(1, 0, 32'h100, 0, 0, 1, rdv, cyc);
      chk("merged_rd", rdv, 32'hDEAD_BEAA);

      // Eviction of the dirty line in set 0
      access(1, 0, 32'h120, 0, 0, 2, rdv, cyc);
      access(1, 0, 32'h140, 0, 0, 2, rdv, cyc);
      chk("evict_wb_addr", lastWbAddr, 32'h100);
      chk("evict_wb_data", lastWbData, 32'hDEAD_BEAA);
      access(1, 0, 32'h120, 0, 0, 1, rdv, cyc);
      chk("still_hit_cyc", cyc, 0);

      // Reset in the middle of a refill
      MemRead = 1'b1; A = 32'h160;
      #1;
      chk("mr_stall_idle", Stall, 1);
      @(posedge CLK); #1;
      chk("mr_memreq", mem_req, 1);
      chk("mr_memwe", mem_we, 0);
      chk("mr_addr", mem_addr, 32'h160);
      RST = 1'b1;
      #1;
      chk("mr_rst_memreq", mem_req, 0);
      chk("mr_rst_stall", Stall, 0);
      chk("mr_rst_hit", hit, 0);
      @(posedge CLK); #1;
      RST = 1'b0; MemRead = 1'b0;
      clearModel();
      gold = mem;
      @(posedge CLK); #1;
      access(1, 0, 32'h120, 0, 0, 2, rdv, cyc);
      chk("post_rst_miss", cyc > 0, 1);

      // Read+write together acts as a store and later writes back
      access(1, 1, 32'h120, 32'h1234_5678, 4'hF, 1, rdv, cyc);
      access(1, 0, 32'h180, 0, 0, 2, rdv, cyc);
      access(1, 0, 32'h1A0, 0, 0, 2, rdv, cyc);
      chk("simul_wb_addr", lastWbAddr, 32'h120);
      chk("simul_wb_data", lastWbData, 32'h1234_5678);

      // Idle with mem_ready chatter
      for (int i = 0; i < 10; i++) begin
         A = $urandom;
         mem_ready = i[0];
         #1;
         chk("idle_memreq", mem_req, 0);
         chk("idle_stall", Stall, 0);
         chk("idle_hit", hit, 0);
         @(posedge CLK); #1;
      end
      mem_ready = 1'b0;
      access(1, 0, 32'h1A0, 0, 0, 1, rdv, cyc);
      chk("idle_kept_line", cyc, 0);

      // Randomized traffic over two sets and six tags
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ad;
         int mode;
         ad = ($urandom_range(0, 5) << 5) | ($urandom_range(0, 1) << 2);
         mode = $urandom_range(0, 2);
         access(mode != 1, mode != 0, ad, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(1, 4), rdv, cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
